// File: rtl/mouse_cursor_overlay.sv
// Purpose: overlays a 16x16 arrow cursor, latched once per frame at sop, onto an RGB pixel stream.
// Latency: one registered stage; an accepted beat appears on out_* the following cycle.
// Backpressure: in_ready = ~out_valid | out_ready; out_* hold while out_valid & ~out_ready.
// Build option: define CURSOR_CLAMP_EN to clamp the latched position so the whole cursor stays on screen.
module mouse_cursor_overlay #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [23:0] FG_RGB   = 24'hFFFFFF,
  parameter logic [23:0] EDGE_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sop,
  input  logic        in_eol,
  input  logic [23:0] in_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eol,
  output logic [23:0] out_rgb
);

`ifdef CURSOR_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  // Largest origin that keeps all 16 cursor columns/rows inside the active area.
  localparam logic [9:0]  MAX_X   = 10'(H_ACTIVE - 16);
  localparam logic [9:0]  MAX_Y   = 10'(V_ACTIVE - 16);
  localparam logic [10:0] CNT_MAX = 11'h7FF;

  // Frame-latched cursor origin and running pixel coordinates.
  logic [9:0]  pos_x, pos_y;
  logic [10:0] x_cnt, y_cnt;

  logic        accept;
  logic [9:0]  lat_x, lat_y;
  logic [9:0]  eff_x, eff_y;
  logic [10:0] px, py;
  logic [10:0] px_inc, py_inc;
  logic [10:0] x_nxt, y_nxt;
  logic signed [11:0] cx, cy;
  logic        cx_in, cy_in, hit, edge_px;
  logic [23:0] pix_rgb;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Candidate origin sampled at sop, optionally clamped so the cursor never clips.
  always_comb begin
    lat_x = mouse_x;
    lat_y = mouse_y;
    if (CLAMP_EN && (mouse_x > MAX_X)) lat_x = MAX_X;
    if (CLAMP_EN && (mouse_y > MAX_Y)) lat_y = MAX_Y;
  end

  // The sop pixel already uses the newly latched origin and sits at (0,0).
  always_comb begin
    eff_x = in_sop ? lat_x : pos_x;
    eff_y = in_sop ? lat_y : pos_y;
    px    = in_sop ? 11'd0 : x_cnt;
    py    = in_sop ? 11'd0 : y_cnt;
  end

  // Saturating next coordinates: a line without eol parks the cursor test off-screen.
  always_comb begin
    px_inc = (px == CNT_MAX) ? px : px + 11'd1;
    py_inc = (py == CNT_MAX) ? py : py + 11'd1;
    if (in_eol) begin
      x_nxt = 11'd0;
      y_nxt = py_inc;
    end else begin
      x_nxt = px_inc;
      y_nxt = py;
    end
  end

  // Arrow hit test on cursor-relative coordinates; negatives mean left/above the cursor.
  always_comb begin
    cx      = $signed({1'b0, px}) - $signed({2'b00, eff_x});
    cy      = $signed({1'b0, py}) - $signed({2'b00, eff_y});
    cx_in   = ~cx[11] & (cx[10:4] == 7'd0);
    cy_in   = ~cy[11] & (cy[10:4] == 7'd0);
    hit     = cx_in & cy_in & (cx[3:0] <= cy[3:0]);
    edge_px = hit & ((cx[3:0] == 4'd0) | (cx[3:0] == cy[3:0]) | (cy[3:0] == 4'hF));
  end

  // Colour selection: outline, interior, or pass-through.
  always_comb begin
    if (edge_px)  pix_rgb = EDGE_RGB;
    else if (hit) pix_rgb = FG_RGB;
    else          pix_rgb = in_rgb;
  end

  // Cursor origin is captured only on an accepted sop beat so it cannot tear mid-frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (accept && in_sop) begin
      pos_x <= lat_x;
      pos_y <= lat_y;
    end
  end

  // Pixel coordinate counters advance once per accepted beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      x_cnt <= x_nxt;
      y_cnt <= y_nxt;
    end
  end

  // Output register: load on accept, drop valid once consumed, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eol   <= 1'b0;
      out_rgb   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sop   <= in_sop;
      out_eol   <= in_eol;
      out_rgb   <= pix_rgb;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
`timescale 1ns/1ps
module tb_mouse_cursor_overlay;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  mouse_x = '0;
  logic [9:0]  mouse_y = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sop = 1'b0;
  logic        in_eol = 1'b0;
  logic [23:0] in_rgb = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sop;
  logic        out_eol;
  logic [23:0] out_rgb;

  int checks = 0;
  int failures = 0;

  logic [23:0] cap [0:639];
  logic        last_sop, last_eol;
  logic [23:0] mon_q [$];

  always #5 clk = ~clk;

  mouse_cursor_overlay dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mouse_x   (mouse_x),
    .mouse_y   (mouse_y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sop    (in_sop),
    .in_eol    (in_eol),
    .in_rgb    (in_rgb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eol   (out_eol),
    .out_rgb   (out_rgb)
  );

  // Downstream view: every transferred beat, sampled mid-cycle.
  always @(negedge clk)
    if (reset_n && out_valid && out_ready) mon_q.push_back(out_rgb);

  // Unique input colour per coordinate, never equal to black or white.
  function automatic logic [23:0] pat(int x, int y);
    logic [9:0] xs, ys;
    xs = x[9:0];
    ys = y[9:0];
    return {4'hA, ys, xs};
  endfunction

  // Reference pixel for a cursor at origin (ox,oy).
  function automatic logic [23:0] ref_px(int x, int y, int ox, int oy);
    int dx, dy;
    dx = x - ox;
    dy = y - oy;
    if (dx < 0 || dy < 0 || dx > 15 || dy > 15 || dx > dy) return pat(x, y);
    if (dx == 0 || dx == dy || dy == 15) return 24'h000000;
    return 24'hFFFFFF;
  endfunction

  task automatic chk(string tag, logic [23:0] got, logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chkb(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive one beat from posedge+1 and return at posedge+1 after it is accepted.
  task automatic send(logic sop, logic eol, int x, int y);
    int budget;
    logic ok;
    in_valid = 1'b1;
    in_sop   = sop;
    in_eol   = eol;
    in_rgb   = pat(x, y);
    budget   = 0;
    ok       = 1'b0;
    while (!ok) begin
      #1;
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) begin
        budget++;
        if (budget > 20) begin
          checks++;
          failures++;
          $error("FAIL accept_timeout x=%0d y=%0d", x, y);
          ok = 1'b1;
        end
      end
    end
    cap[x]   = out_rgb;
    last_sop = out_sop;
    last_eol = out_eol;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eol   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(int y, int len, logic sop);
    for (int x = 0; x < len; x++) send(sop && (x == 0), x == len - 1, x, y);
  endtask

  initial begin
    logic [23:0] got;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_out_sop", out_sop, 1'b0);
    chkb("rst_out_eol", out_eol, 1'b0);
    chk("rst_out_rgb", out_rgb, 24'h000000);
    chkb("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;
    idle(1);

    // Frame 1: cursor at (100,50); mouse moves to (200,200) mid-frame
    mouse_x = 10'd100;
    mouse_y = 10'd50;
    for (int y = 0; y < 48; y++) begin
      line(y, 1, y == 0);
      if (y == 0) begin
        chkb("f1_sop_flag", last_sop, 1'b1);
        chkb("f1_sopeol_flag", last_eol, 1'b1);
      end
      if (y == 1) begin
        chkb("f1_row1_sop", last_sop, 1'b0);
        chkb("f1_row1_eol", last_eol, 1'b1);
      end
    end
    for (int y = 48; y < 68; y++) begin
      if (y == 60) begin
        idle(2);
        mon_q.delete();
        for (int x = 0; x < 120; x++) begin
          if (x == 105) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_sop    = 1'b0;
            in_eol    = 1'b0;
            in_rgb    = pat(105, 60);
            #1;
            chkb("stall_in_ready", in_ready, 1'b0);
            chk("stall_held", out_rgb, ref_px(104, 60, 100, 50));
            repeat (5) begin
              @(posedge clk);
              #1;
              chk("stall_rgb_stable", out_rgb, ref_px(104, 60, 100, 50));
              chkb("stall_out_valid", out_valid, 1'b1);
              chkb("stall_in_ready_low", in_ready, 1'b0);
            end
            out_ready = 1'b1;
          end
          send(1'b0, x == 119, x, 60);
        end
        idle(2);
        chk("row60_count", 24'(mon_q.size()), 24'd120);
        for (int x = 0; x < 120; x++) begin
          got = (x < mon_q.size()) ? mon_q[x] : 24'hxxxxxx;
          chk("row60_golden", got, ref_px(x, 60, 100, 50));
        end
      end else begin
        line(y, 120, 1'b0);
      end
      if (y == 50) begin
        chk("f1_100_50", cap[100], 24'h000000);
        chk("f1_99_50", cap[99], pat(99, 50));
        chk("f1_101_50", cap[101], pat(101, 50));
      end
      if (y == 55) begin
        chk("f1_101_55", cap[101], 24'hFFFFFF);
        chk("f1_110_55", cap[110], pat(110, 55));
        chk("f1_105_55", cap[105], 24'h000000);
        mouse_x = 10'd200;
        mouse_y = 10'd200;
      end
      if (y == 57) begin
        chk("f1_keep_100_57", cap[100], 24'h000000);
        chk("f1_keep_101_57", cap[101], 24'hFFFFFF);
      end
      if (y == 65) begin
        chk("f1_100_65", cap[100], 24'h000000);
        chk("f1_108_65", cap[108], 24'h000000);
        chk("f1_115_65", cap[115], 24'h000000);
      end
      if (y == 66) chk("f1_100_66", cap[100], pat(100, 66));
    end
    idle(1);

    // Frame 2: cursor now at (200,200) only
    for (int y = 0; y < 50; y++) line(y, 1, y == 0);
    for (int y = 50; y < 53; y++) line(y, 120, 1'b0);
    chk("f2_old_100_50", ref_px(100, 50, 200, 200), pat(100, 50));
    for (int y = 53; y < 198; y++) line(y, 1, 1'b0);
    for (int y = 198; y < 217; y++) begin
      line(y, 220, 1'b0);
      if (y == 198) chk("f2_200_198", cap[200], pat(200, 198));
      if (y == 200) begin
        chk("f2_200_200", cap[200], 24'h000000);
        chk("f2_199_200", cap[199], pat(199, 200));
      end
      if (y == 210) chk("f2_205_210", cap[205], 24'hFFFFFF);
      if (y == 215) chk("f2_215_215", cap[215], 24'h000000);
      if (y == 216) chk("f2_200_216", cap[200], pat(200, 216));
    end
    idle(1);

    // Frame 3: cursor near bottom-right corner
    mouse_x = 10'd630;
    mouse_y = 10'd475;
    line(0, 640, 1'b1);
    chk("f3_0_0", cap[0], pat(0, 0));
    chk("f3_630_0", cap[630], pat(630, 0));
    chkb("f3_row0_eol", last_eol, 1'b1);
    for (int y = 1; y < 460; y++) line(y, 1, 1'b0);
    for (int y = 460; y < 480; y++) begin
      line(y, 640, 1'b0);
`ifdef CURSOR_CLAMP_EN
      if (y == 464) begin
        chk("f3c_624_464", cap[624], 24'h000000);
        chk("f3c_623_464", cap[623], pat(623, 464));
      end
      if (y == 475) chk("f3c_630_475", cap[630], 24'hFFFFFF);
      if (y == 476) chk("f3c_631_476", cap[631], 24'hFFFFFF);
      if (y == 479) begin
        chk("f3c_639_479", cap[639], 24'h000000);
        chk("f3c_625_479", cap[625], 24'h000000);
        chk("f3c_0_479", cap[0], pat(0, 479));
      end
`else
      if (y == 464) chk("f3_624_464", cap[624], pat(624, 464));
      if (y == 475) begin
        chk("f3_630_475", cap[630], 24'h000000);
        chk("f3_629_475", cap[629], pat(629, 475));
        chk("f3_0_475", cap[0], pat(0, 475));
      end
      if (y == 477) chk("f3_631_477", cap[631], 24'hFFFFFF);
      if (y == 479) begin
        chk("f3_632_479", cap[632], 24'hFFFFFF);
        chk("f3_634_479", cap[634], 24'h000000);
        chk("f3_639_479", cap[639], pat(639, 479));
        chk("f3_0_479", cap[0], pat(0, 479));
      end
`endif
    end
    idle(1);

    // Frame 4: reset asserted mid-line
    mouse_x = 10'd20;
    mouse_y = 10'd10;
    for (int y = 0; y < 5; y++) line(y, 1, y == 0);
    for (int x = 0; x < 16; x++) send(1'b0, 1'b0, x, 5);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chkb("mrst_out_valid_a", out_valid, 1'b0);
    chk("mrst_out_rgb_a", out_rgb, 24'h000000);
    @(posedge clk);
    #1;
    chkb("mrst_out_valid_b", out_valid, 1'b0);
    chk("mrst_out_rgb_b", out_rgb, 24'h000000);
    chkb("mrst_out_sop_b", out_sop, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    // Before the next sop: origin (0,0), counters from 0
    send(1'b0, 1'b0, 0, 0);
    chk("presop_0_0", cap[0], 24'h000000);
    send(1'b0, 1'b0, 1, 0);
    chk("presop_1_0", cap[1], pat(1, 0));
    chkb("presop_sop_flag", last_sop, 1'b0);
    chkb("presop_eol_flag", last_eol, 1'b0);
    idle(1);

    // Frame 5: cursor at (20,10) after reset
    for (int y = 0; y < 10; y++) line(y, 1, y == 0);
    for (int y = 10; y < 27; y++) begin
      line(y, 40, 1'b0);
      if (y == 10) chk("f5_20_10", cap[20], 24'h000000);
      if (y == 15) chk("f5_21_15", cap[21], 24'hFFFFFF);
      if (y == 25) begin
        chk("f5_20_25", cap[20], 24'h000000);
        chk("f5_36_25", cap[36], pat(36, 25));
      end
      if (y == 26) chk("f5_20_26", cap[20], pat(20, 26));
    end
    idle(1);

    // Frame 6: one-pixel lines
    mouse_x = 10'd0;
    mouse_y = 10'd1;
    send(1'b1, 1'b1, 0, 0);
    chk("onepx_y0", cap[0], pat(0, 0));
    send(1'b0, 1'b1, 0, 1);
    chk("onepx_y1", cap[0], 24'h000000);
    send(1'b0, 1'b1, 0, 2);
    chk("onepx_y2", cap[0], 24'h000000);
    send(1'b0, 1'b0, 0, 3);
    chk("row3_x0", cap[0], 24'h000000);
    send(1'b0, 1'b0, 1, 3);
    chk("row3_x1", cap[1], 24'hFFFFFF);
    send(1'b0, 1'b0, 2, 3);
    chk("row3_x2", cap[2], 24'h000000);
    send(1'b0, 1'b1, 3, 3);
    chk("row3_x3", cap[3], pat(3, 3));
    mouse_y = 10'd0;
    send(1'b1, 1'b1, 0, 0);
    chk("onepx_cursor00", cap[0], 24'h000000);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
